lvds_rx_gearbox_sync: RTL and testbench

//  Multi-lane, parametrised receive gearbox + clock-domain crossing placed after the LVDS 1:N deserializers.

---
 rtl/lvds_rx_gearbox_sync.sv | 177 +++++++++++++++++
 tb/tb_lvds_rx_gearbox_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_gearbox_sync.sv
// Receive gearbox after the LVDS deserializers: splits each captured word into MSB-first chunks
// and carries them into the RCLOCK domain through a gray-pointer async FIFO.
module lvds_rx_gearbox_sync #(
   parameter int unsigned DW       = 7,
   parameter int unsigned RATIO    = 2,
   parameter int unsigned LANES    = 1,
   parameter int unsigned SLOT_GAP = 3,
   parameter int unsigned FIFO_AW  = 4
) (
   input  logic                        WCLK,
   input  logic                        RESET,
   input  logic                        RCLOCK,
   input  logic [LANES*RATIO*DW-1:0]   WDATA,
   input  logic                        enable,
   input  logic                        align_i,
   output logic [LANES*DW-1:0]         DATA_OUT,
   output logic                        DATA_VALID,
   output logic                        align_o,
   output logic                        ovf_sticky,
   input  logic                        ovf_clr
);

   localparam int unsigned WW    = LANES * DW + 1;
   localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned SW    = (SLOT_GAP > 1) ? $clog2(SLOT_GAP) : 1;
   localparam int unsigned PW    = FIFO_AW + 1;
   localparam int unsigned DEPTH = 2 ** FIFO_AW;

   typedef enum logic {StIdle, StEmit} state_e;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = int'(PW) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Write domain state
   state_e                       state_q, state_d;
   logic [CW-1:0]                chunk_q, chunk_d;
   logic [SW-1:0]                slot_q, slot_d;
   logic [LANES*RATIO*DW-1:0]    hold_q, hold_d;
   logic                         hold_align_q, hold_align_d;
   logic                         ovf_q, ovf_d;
   logic [PW-1:0]                wptr_bin_q, wptr_bin_d, wptr_gray_q;
   logic [PW-1:0]                rsync1_q, rsync2_q;
   logic                         slot_fire, last_fire, abort, wr_full, wr_en, drop;
   logic [WW-1:0]                wr_entry;
   logic [PW-1:0]                rptr_wside;

   logic [WW-1:0]                mem [DEPTH];

   // Read domain state
   logic [PW-1:0]                rptr_bin_q, rptr_bin_d, rptr_gray_q;
   logic [PW-1:0]                wsync1_q, wsync2_q;
   logic [LANES*DW-1:0]          data_q, data_d;
   logic                         align_q, align_d, valid_q, valid_d, rd_empty;
   logic [WW-1:0]                rd_entry;

   always_comb begin
      state_d      = state_q;
      chunk_d      = chunk_q;
      slot_d       = slot_q;
      hold_d       = hold_q;
      hold_align_d = hold_align_q;
      slot_fire    = (state_q == StEmit) && (slot_q == '0);
      last_fire    = slot_fire && (chunk_q == CW'(RATIO - 1));
      // An enable on the final write edge is a clean back-to-back word, not an abort
      abort        = enable && (state_q == StEmit) && !last_fire;
      rptr_wside   = gray2bin(rsync2_q);
      wr_full      = (wptr_bin_q[PW-1] != rptr_wside[PW-1]) &&
                     (wptr_bin_q[FIFO_AW-1:0] == rptr_wside[FIFO_AW-1:0]);
      wr_en        = slot_fire && !wr_full;
      drop         = slot_fire && wr_full;
      wptr_bin_d   = wr_en ? wptr_bin_q + PW'(1) : wptr_bin_q;

      wr_entry         = '0;
      wr_entry[WW-1]   = hold_align_q;
      for (int l = 0; l < int'(LANES); l++) begin
         wr_entry[l*DW +: DW] =
            hold_q[l*RATIO*DW + (int'(RATIO) - 1 - int'(chunk_q))*DW +: DW];
      end

      if (slot_fire) begin
         if (last_fire) state_d = StIdle;
         else           chunk_d = chunk_q + CW'(1);
         slot_d = SW'(SLOT_GAP - 1);
      end else if (state_q == StEmit) begin
         slot_d = slot_q - SW'(1);
      end

      if (enable) begin
         hold_d       = WDATA;
         hold_align_d = align_i;
         state_d      = StEmit;
         chunk_d      = '0;
         slot_d       = '0;
      end

      ovf_d = (abort || drop) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge WCLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= StIdle;
         chunk_q      <= '0;
         slot_q       <= '0;
         hold_q       <= '0;
         hold_align_q <= 1'b0;
         ovf_q        <= 1'b0;
         wptr_bin_q   <= '0;
         wptr_gray_q  <= '0;
         rsync1_q     <= '0;
         rsync2_q     <= '0;
      end else begin
         state_q      <= state_d;
         chunk_q      <= chunk_d;
         slot_q       <= slot_d;
         hold_q       <= hold_d;
         hold_align_q <= hold_align_d;
         ovf_q        <= ovf_d;
         wptr_bin_q   <= wptr_bin_d;
         wptr_gray_q  <= bin2gray(wptr_bin_d);
         rsync1_q     <= rptr_gray_q;
         rsync2_q     <= rsync1_q;
      end
   end

   always_ff @(posedge WCLK) begin
      if (wr_en) mem[wptr_bin_q[FIFO_AW-1:0]] <= wr_entry;
   end

   always_comb begin
      rd_empty   = (rptr_gray_q == wsync2_q);
      rd_entry   = mem[rptr_bin_q[FIFO_AW-1:0]];
      rptr_bin_d = rptr_bin_q;
      data_d     = '0;
      align_d    = 1'b0;
      valid_d    = 1'b0;
      if (!rd_empty) begin
         rptr_bin_d = rptr_bin_q + PW'(1);
         data_d     = rd_entry[LANES*DW-1:0];
         align_d    = rd_entry[WW-1];
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge RCLOCK or negedge RESET) begin
      if (!RESET) begin
         rptr_bin_q  <= '0;
         rptr_gray_q <= '0;
         wsync1_q    <= '0;
         wsync2_q    <= '0;
         data_q      <= '0;
         align_q     <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         rptr_bin_q  <= rptr_bin_d;
         rptr_gray_q <= bin2gray(rptr_bin_d);
         wsync1_q    <= wptr_gray_q;
         wsync2_q    <= wsync1_q;
         data_q      <= data_d;
         align_q     <= align_d;
         valid_q     <= valid_d;
      end
   end

   assign DATA_OUT   = data_q;
   assign DATA_VALID = valid_q;
   assign align_o    = align_q;
   assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_lvds_rx_gearbox_sync.sv
// Bench for lvds_rx_gearbox_sync: expected-chunk queue built from word/abort/overflow rules,
// checked on every RCLOCK cycle, plus literal expectations for the directed cases.
module tb_lvds_rx_gearbox_sync;

   logic        wclk = 1'b0;
   logic        rclk = 1'b0;
   logic        rst_n = 1'b0;
   int          rhalf = 19;
   bit          rclk_run = 1'b1;

   logic [13:0] wdata = '0;
   logic        en = 1'b0, al = 1'b0, clr = 1'b0;
   logic [6:0]  dout;
   logic        dv, ao, ovf;

   logic [55:0] wdata2 = '0;
   logic        en2 = 1'b0;
   logic [13:0] dout2;
   logic        dv2, ao2, ovf2;

   int          n_assert = 0;
   int          n_fail = 0;
   logic [7:0]  sb[$];
   logic [7:0]  rx_log[$];
   logic [13:0] log2[$];

   lvds_rx_gearbox_sync u_dut (
      .WCLK(wclk), .RESET(rst_n), .RCLOCK(rclk), .WDATA(wdata), .enable(en), .align_i(al),
      .DATA_OUT(dout), .DATA_VALID(dv), .align_o(ao), .ovf_sticky(ovf), .ovf_clr(clr)
   );

   lvds_rx_gearbox_sync #(.DW(7), .RATIO(4), .LANES(2), .SLOT_GAP(3), .FIFO_AW(4)) u_dut2 (
      .WCLK(wclk), .RESET(rst_n), .RCLOCK(rclk), .WDATA(wdata2), .enable(en2), .align_i(1'b0),
      .DATA_OUT(dout2), .DATA_VALID(dv2), .align_o(ao2), .ovf_sticky(ovf2), .ovf_clr(1'b0)
   );

   always #19 wclk = ~wclk;

   initial begin
      #3;
      forever begin
         #(rhalf);
         if (rclk_run) rclk = ~rclk;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Chunk k of a default-parameter word: the k-th 7-bit slice counting from the MSB end
   function automatic logic [6:0] chunk_of(input logic [13:0] w, input int k);
      logic [13:0] s;
      s = w >> ((1 - k) * 7);
      return s[6:0];
   endfunction

   always @(negedge rclk) begin
      if (rst_n) begin
         if (dv) begin
            rx_log.push_back({ao, dout});
            if (sb.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL extra_chunk: got %0h, required no chunk", {ao, dout});
            end else begin
               check("chunk", {24'h0, ao, dout}, {24'h0, sb.pop_front()});
            end
         end else begin
            check("idle_zero", {24'h0, ao, dout}, 32'h0);
         end
      end
   end

   always @(negedge rclk) begin
      if (rst_n) begin
         if (dv2) log2.push_back(dout2);
         else     check("idle_zero2", {17'h0, ao2, dout2}, 32'h0);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge wclk);
   endtask

   // Pushes the first nexp chunks the model expects, then strobes enable for one edge
   task automatic send_word(input logic [13:0] w, input logic a, input int nexp);
      for (int k = 0; k < nexp; k++) sb.push_back({a, chunk_of(w, k)});
      @(negedge wclk);
      wdata = w;
      al    = a;
      en    = 1'b1;
      @(negedge wclk);
      en    = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 400) begin
         @(negedge wclk);
         t++;
      end
      check(name, sb.size(), 0);
      wait_cyc(10);
   endtask

   task automatic pulse_clr();
      @(negedge wclk);
      clr = 1'b1;
      @(negedge wclk);
      clr = 1'b0;
   endtask

   initial begin
      logic [13:0] w;
      logic [13:0] exp2 [4];
      int          t;
      int          rh [3];

      wait_cyc(3);
      check("reset_outputs", {22'h0, dv, ao, ovf, dout}, 32'h0);
      rst_n = 1'b1;
      wait_cyc(3);

      // Directed word, MSB chunk first
      send_word(14'h2A55, 1'b1, 2);
      drain("t1_drain");
      check("t1_chunk0", (rx_log.size() > 0) ? rx_log[0] : 8'h0, 8'hD4);
      check("t1_chunk1", (rx_log.size() > 1) ? rx_log[1] : 8'h0, 8'hD5);
      check("t1_no_ovf", ovf, 1'b0);

      // Two lanes, four chunks each
      @(negedge wclk);
      wdata2 = {28'hFEDCBA9, 28'h0123456};
      en2    = 1'b1;
      @(negedge wclk);
      en2    = 1'b0;
      t = 0;
      while (log2.size() < 4 && t < 60) begin
         @(negedge wclk);
         t++;
      end
      wait_cyc(10);
      check("t2_count", log2.size(), 4);
      exp2 = '{14'h3F80, 14'h1BC8, 14'h0BE8, 14'h14D6};
      for (int i = 0; i < 4; i++)
         check("t2_chunk", (i < log2.size()) ? log2[i] : 14'h0, exp2[i]);
      check("t2_no_ovf", ovf2, 1'b0);

      // Abort two cycles in, with ovf_clr held across the abort edge: set wins
      send_word(14'h1234, 1'b0, 1);
      clr = 1'b1;
      send_word(14'h3ABC, 1'b1, 2);
      clr = 1'b0;
      check("t3_set_wins", ovf, 1'b1);
      drain("t3_abort_drain");
      check("t3_ovf_held", ovf, 1'b1);
      pulse_clr();
      check("t3_ovf_cleared", ovf, 1'b0);
      // Enable on the final chunk edge: both words complete, no abort
      send_word(14'h0F0F, 1'b1, 2);
      wait_cyc(2);
      send_word(14'h30C3, 1'b0, 2);
      drain("t3_coincide_drain");
      check("t3_coincide_no_ovf", ovf, 1'b0);

      // Reader stalled: 20 writes into 16 entries
      wait_cyc(5);
      rclk_run = 1'b0;
      wait_cyc(4);
      for (int i = 0; i < 10; i++) begin
         w = 14'(16'h0101 * i + 16'h0A05);
         send_word(w, i[0], (i < 8) ? 2 : 0);
         wait_cyc(4);
      end
      check("t4_overflow", ovf, 1'b1);
      check("t4_no_output_stalled", dv, 1'b0);
      rclk_run = 1'b1;
      drain("t4_drain");
      pulse_clr();
      check("t4_ovf_cleared", ovf, 1'b0);

      // Random words at several read/write clock ratios
      rh = '{27, 19, 10};
      for (int r = 0; r < 3; r++) begin
         rhalf = rh[r];
         wait_cyc(4);
         for (int i = 0; i < 8; i++) begin
            w = 14'($urandom);
            send_word(w, 1'($urandom_range(1)), 2);
            wait_cyc(4);
         end
         drain("t5_drain");
      end
      check("t5_no_ovf", ovf, 1'b0);

      // Reset while a chunk is being presented
      rhalf = 19;
      wait_cyc(4);
      send_word(14'h2AAA, 1'b1, 2);
      t = 0;
      while (!dv && t < 20) begin
         @(negedge wclk);
         t++;
      end
      check("t6_valid_seen", dv, 1'b1);
      #3 rst_n = 1'b0;
      #1 check("t6a_async_clear", {22'h0, dv, ao, ovf, dout}, 32'h0);
      sb.delete();
      wait_cyc(3);
      rst_n = 1'b1;

      // Reset with FIFO half full and a word mid-emission
      wait_cyc(4);
      rclk_run = 1'b0;
      wait_cyc(3);
      for (int i = 0; i < 4; i++) begin
         send_word(14'(16'h1357 + 16'h0111 * i), 1'b0, 0);
         if (i < 3) wait_cyc(4);
      end
      send_word(14'h1FFF, 1'b1, 0);
      check("t6_ovf_before_reset", ovf, 1'b1);
      wait_cyc(1);
      #3 rst_n = 1'b0;
      #1 check("t6b_async_clear", {22'h0, dv, ao, ovf, dout}, 32'h0);
      wait_cyc(3);
      rst_n = 1'b1;
      rclk_run = 1'b1;
      wait_cyc(6);
      send_word(14'h2C4B, 1'b1, 2);
      drain("t6_drain");
      check("t6_first_word_after_reset",
            (rx_log.size() > 1) ? {rx_log[rx_log.size()-2], rx_log[rx_log.size()-1]} : 16'h0,
            {1'b1, chunk_of(14'h2C4B, 0), 1'b1, chunk_of(14'h2C4B, 1)});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
